// File: rtl/ysyx_22041207_pipe_ctrl.sv
// Hazard/sequencing controller: hold and flush controls for the 5-stage pipeline registers.
// Optional perf counters are enabled with `define YSYX_22041207_PIPE_PERF_EN.
module ysyx_22041207_pipe_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_mc_start,
    input  logic        ex_mc_done,
    input  logic        ex_redirect,
    input  logic        mem_wait,
    output logic        pc_hold,
    output logic        if_id_bubble,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {RUN, LDU, MCW} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   ldu_cnt_reg, ldu_cnt_next;
    logic               redir_pend_reg, redir_pend_next;
    logic               mc_done_seen_reg, mc_done_seen_next;
    logic               hz;
    logic               redir_svc;

    assign hz = ex_is_load && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= RUN;
            ldu_cnt_reg      <= '0;
            redir_pend_reg   <= 1'b0;
            mc_done_seen_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            ldu_cnt_reg      <= ldu_cnt_next;
            redir_pend_reg   <= redir_pend_next;
            mc_done_seen_reg <= mc_done_seen_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        ldu_cnt_next      = ldu_cnt_reg;
        redir_pend_next   = redir_pend_reg;
        mc_done_seen_next = mc_done_seen_reg;
        redir_svc         = 1'b0;
        pc_hold           = 1'b0;
        if_id_bubble      = 1'b0;
        if_id_flush       = 1'b0;
        id_ex_bubble      = 1'b0;
        id_ex_flush       = 1'b0;
        ex_mem_bubble     = 1'b0;
        ex_mem_flush      = 1'b0;
        mem_wb_flush      = 1'b0;

        if (!rst_n) begin
            // Drain the whole pipeline while reset is held.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_wait) begin
            pc_hold       = 1'b1;
            if_id_bubble  = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            mem_wb_flush  = 1'b1;
            if (ex_redirect) redir_pend_next   = 1'b1;
            if (ex_mc_done)  mc_done_seen_next = 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    // A start that completes in the same cycle never enters the wait state.
                    if (ex_mc_start && !ex_mc_done) begin
                        state_next   = MCW;
                        pc_hold      = 1'b1;
                        if_id_bubble = 1'b1;
                        id_ex_bubble = 1'b1;
                        ex_mem_flush = 1'b1;
                        if (ex_redirect) redir_pend_next = 1'b1;
                    end else if (ex_redirect || redir_pend_reg) begin
                        if_id_flush     = 1'b1;
                        id_ex_flush     = 1'b1;
                        redir_pend_next = 1'b0;
                        redir_svc       = 1'b1;
                    end else if (hz) begin
                        pc_hold      = 1'b1;
                        if_id_bubble = 1'b1;
                        id_ex_flush  = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_next   = LDU;
                            ldu_cnt_next = CNT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                LDU: begin
                    if (ex_redirect || redir_pend_reg) begin
                        if_id_flush     = 1'b1;
                        id_ex_flush     = 1'b1;
                        redir_pend_next = 1'b0;
                        redir_svc       = 1'b1;
                        state_next      = RUN;
                        ldu_cnt_next    = '0;
                    end else begin
                        pc_hold      = 1'b1;
                        if_id_bubble = 1'b1;
                        id_ex_flush  = 1'b1;
                        ldu_cnt_next = ldu_cnt_reg - CNT_W'(1);
                        if (ldu_cnt_reg <= CNT_W'(1)) state_next = RUN;
                    end
                end
                MCW: begin
                    pc_hold      = 1'b1;
                    if_id_bubble = 1'b1;
                    id_ex_bubble = 1'b1;
                    ex_mem_flush = 1'b1;
                    if (ex_redirect) redir_pend_next = 1'b1;
                    if (ex_mc_done || mc_done_seen_reg) begin
                        state_next        = RUN;
                        mc_done_seen_next = 1'b0;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

`ifdef YSYX_22041207_PIPE_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (pc_hold && (perf_stall_reg != 32'hFFFF_FFFF))
                perf_stall_reg <= perf_stall_reg + 32'd1;
            if (redir_svc && (perf_flush_reg != 32'hFFFF_FFFF))
                perf_flush_reg <= perf_flush_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_reg;
    assign perf_flush_cnt = perf_flush_reg;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_22041207_pipe_ctrl.sv
// Scoreboard bench: two controllers (LOAD_LAT=1 and 3) share stimulus; a reference model queues expectations.
module tb_ysyx_22041207_pipe_ctrl;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       load;
        logic       mc_start;
        logic       mc_done;
        logic       redirect;
        logic       mem_wait;
    } stim_t;

    typedef struct {
        string       tag;
        int          seq;
        logic [7:0]  ctl0;
        logic [7:0]  ctl1;
        logic [31:0] st0;
        logic [31:0] fl0;
        logic [31:0] st1;
        logic [31:0] fl1;
    } exp_t;

    // {pc_hold, if_id_bubble, if_id_flush, id_ex_bubble, id_ex_flush, ex_mem_bubble, ex_mem_flush, mem_wb_flush}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_RST  = 8'b0010_1011;
    localparam logic [7:0] C_WAIT = 8'b1101_0101;
    localparam logic [7:0] C_MC   = 8'b1101_0010;
    localparam logic [7:0] C_FLU  = 8'b0010_1000;
    localparam logic [7:0] C_BUB  = 8'b1100_1000;

    logic  clk = 1'b0;
    stim_t s;
    exp_t  sb_q[$];
    int    compared = 0;
    int    mismatched = 0;
    int    seq_n = 0;

    // Reference model: per-instance progress tracked as counts and flags.
    int bubbles_left[2];
    bit in_mc[2];
    bit pend[2];
    bit seen[2];
    int stall_c[2];
    int flush_c[2];

    always #5 clk = ~clk;

    logic u1_pc_hold, u1_ifb, u1_iff, u1_idb, u1_idf, u1_exb, u1_exf, u1_wbf;
    logic u3_pc_hold, u3_ifb, u3_iff, u3_idb, u3_idf, u3_exb, u3_exf, u3_wbf;
    logic [31:0] u1_st, u1_fl, u3_st, u3_fl;
    logic [7:0] act0, act1;

    assign act0 = {u1_pc_hold, u1_ifb, u1_iff, u1_idb, u1_idf, u1_exb, u1_exf, u1_wbf};
    assign act1 = {u3_pc_hold, u3_ifb, u3_iff, u3_idb, u3_idf, u3_exb, u3_exf, u3_wbf};

    ysyx_22041207_pipe_ctrl #(.LOAD_LAT(1), .CNT_W(3)) u_lat1 (
        .clk(clk), .rst_n(s.rst_n), .id_rs1(s.rs1), .id_rs2(s.rs2),
        .id_use_rs1(s.use1), .id_use_rs2(s.use2), .ex_rd(s.rd), .ex_is_load(s.load),
        .ex_mc_start(s.mc_start), .ex_mc_done(s.mc_done), .ex_redirect(s.redirect),
        .mem_wait(s.mem_wait), .pc_hold(u1_pc_hold), .if_id_bubble(u1_ifb),
        .if_id_flush(u1_iff), .id_ex_bubble(u1_idb), .id_ex_flush(u1_idf),
        .ex_mem_bubble(u1_exb), .ex_mem_flush(u1_exf), .mem_wb_flush(u1_wbf),
        .perf_stall_cnt(u1_st), .perf_flush_cnt(u1_fl)
    );

    ysyx_22041207_pipe_ctrl #(.LOAD_LAT(3), .CNT_W(3)) u_lat3 (
        .clk(clk), .rst_n(s.rst_n), .id_rs1(s.rs1), .id_rs2(s.rs2),
        .id_use_rs1(s.use1), .id_use_rs2(s.use2), .ex_rd(s.rd), .ex_is_load(s.load),
        .ex_mc_start(s.mc_start), .ex_mc_done(s.mc_done), .ex_redirect(s.redirect),
        .mem_wait(s.mem_wait), .pc_hold(u3_pc_hold), .if_id_bubble(u3_ifb),
        .if_id_flush(u3_iff), .id_ex_bubble(u3_idb), .id_ex_flush(u3_idf),
        .ex_mem_bubble(u3_exb), .ex_mem_flush(u3_exf), .mem_wb_flush(u3_wbf),
        .perf_stall_cnt(u3_st), .perf_flush_cnt(u3_fl)
    );

    task automatic model_cycle(input int k, input int lat, input stim_t st, output logic [7:0] ctl);
        bit hazard;
        hazard = st.load && (st.rd != 0) &&
                 ((st.use1 && st.rs1 == st.rd) || (st.use2 && st.rs2 == st.rd));
        ctl = C_NONE;
        if (!st.rst_n) begin
            ctl = C_RST;
            bubbles_left[k] = 0; in_mc[k] = 0; pend[k] = 0; seen[k] = 0;
            stall_c[k] = 0; flush_c[k] = 0;
            return;
        end
        if (st.mem_wait) begin
            ctl = C_WAIT;
            if (st.redirect) pend[k] = 1;
            if (st.mc_done)  seen[k] = 1;
        end else if (in_mc[k]) begin
            ctl = C_MC;
            if (st.redirect) pend[k] = 1;
            if (st.mc_done || seen[k]) begin in_mc[k] = 0; seen[k] = 0; end
        end else if (bubbles_left[k] > 0) begin
            if (st.redirect || pend[k]) begin
                ctl = C_FLU; pend[k] = 0; bubbles_left[k] = 0; flush_c[k]++;
            end else begin
                ctl = C_BUB; bubbles_left[k]--;
            end
        end else if (st.mc_start && !st.mc_done) begin
            ctl = C_MC; in_mc[k] = 1;
            if (st.redirect) pend[k] = 1;
        end else if (st.redirect || pend[k]) begin
            ctl = C_FLU; pend[k] = 0; flush_c[k]++;
        end else if (hazard) begin
            ctl = C_BUB; bubbles_left[k] = lat - 1;
        end
        if (ctl[7]) stall_c[k]++;
    endtask

    task automatic apply(input stim_t st, input string tag);
        exp_t e;
        logic [7:0] c0, c1;
        @(posedge clk);
        #1;
        s = st;
        if (!st.rst_n) begin
            stall_c[0] = 0; flush_c[0] = 0; stall_c[1] = 0; flush_c[1] = 0;
        end
        e.tag = tag;
        e.seq = seq_n++;
`ifdef YSYX_22041207_PIPE_PERF_EN
        e.st0 = stall_c[0]; e.fl0 = flush_c[0];
        e.st1 = stall_c[1]; e.fl1 = flush_c[1];
`else
        e.st0 = 0; e.fl0 = 0; e.st1 = 0; e.fl1 = 0;
`endif
        model_cycle(0, 1, st, c0);
        model_cycle(1, 3, st, c1);
        e.ctl0 = c0;
        e.ctl1 = c1;
        sb_q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t t;
        t = '0;
        t.rst_n = 1'b1;
        return t;
    endfunction

    function automatic stim_t hazard_stim();
        stim_t t;
        t = idle();
        t.load = 1'b1; t.rd = 5'd5; t.rs1 = 5'd5; t.use1 = 1'b1;
        return t;
    endfunction

    task automatic chk_ctl(input string tag, input int seq, input string who,
                           input logic [7:0] act, input logic [7:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s#%0d %s ctl got=%b want=%b", tag, seq, who, act, exp_v);
        end
    endtask

    task automatic chk_cnt(input string tag, input int seq, input string who,
                           input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s#%0d %s got=%0d want=%0d", tag, seq, who, act, exp_v);
        end
    endtask

    // Monitor: outputs are settled by negedge, which is where the pipeline registers sample them.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk_ctl(e.tag, e.seq, "lat1", act0, e.ctl0);
                chk_ctl(e.tag, e.seq, "lat3", act1, e.ctl1);
                chk_cnt(e.tag, e.seq, "lat1 stall", u1_st, e.st0);
                chk_cnt(e.tag, e.seq, "lat1 flush", u1_fl, e.fl0);
                chk_cnt(e.tag, e.seq, "lat3 stall", u3_st, e.st1);
                chk_cnt(e.tag, e.seq, "lat3 flush", u3_fl, e.fl1);
                compared++;
                if ((act0[6] & act0[5]) | (act0[4] & act0[3]) | (act0[2] & act0[1]) |
                    (act1[6] & act1[5]) | (act1[4] & act1[3]) | (act1[2] & act1[1])) begin
                    mismatched++;
                    $display("FAIL %s#%0d excl flush+bubble lat1=%b lat3=%b", e.tag, e.seq, act0, act1);
                end
                $display("txn %0d %s lat1=%b lat3=%b", e.seq, e.tag, act0, act1);
            end
        end
    end

    initial begin
        stim_t t;
        s = '0;
        for (int k = 0; k < 2; k++) begin
            bubbles_left[k] = 0; in_mc[k] = 0; pend[k] = 0; seen[k] = 0;
            stall_c[k] = 0; flush_c[k] = 0;
        end
        t = '0;
        repeat (2) apply(t, "reset");

        apply(hazard_stim(), "ldu");
        repeat (4) apply(idle(), "ldu_after");
        t = hazard_stim(); t.rd = 5'd0; t.rs1 = 5'd0;
        apply(t, "ldu_rd0");
        t = hazard_stim(); t.use1 = 1'b0; t.use2 = 1'b1; t.rs2 = 5'd5; t.rs1 = 5'd7;
        apply(t, "ldu_rs2");
        repeat (3) apply(idle(), "idle");

        apply(hazard_stim(), "ldu_redir");
        t = idle(); t.redirect = 1'b1;
        apply(t, "ldu_redir");
        repeat (3) apply(idle(), "after_redir");

        t = idle(); t.mc_start = 1'b1;
        apply(t, "mc");
        for (int i = 1; i <= 6; i++) begin
            t = idle();
            t.redirect = (i == 2);
            t.mc_done  = (i == 6);
            apply(t, "mc");
        end
        repeat (3) apply(idle(), "mc_after");

        t = idle(); t.mc_start = 1'b1;
        apply(t, "mc_wait");
        apply(idle(), "mc_wait");
        for (int i = 0; i < 4; i++) begin
            t = idle(); t.mem_wait = 1'b1; t.mc_done = (i == 1);
            apply(t, "mc_wait");
        end
        repeat (3) apply(idle(), "mc_wait_after");

        t = idle(); t.mc_start = 1'b1; t.mc_done = 1'b1;
        apply(t, "mc_same");
        t = idle(); t.mc_start = 1'b1; t.redirect = 1'b1;
        apply(t, "mc_redir");
        t = idle(); t.mc_done = 1'b1;
        apply(t, "mc_redir");
        repeat (2) apply(idle(), "mc_redir_after");

        apply(hazard_stim(), "rst_mid");
        apply(idle(), "rst_mid");
        t = hazard_stim(); t.rst_n = 1'b0;
        repeat (2) apply(t, "rst_mid");
        repeat (3) apply(idle(), "rst_after");

        t = idle(); t.redirect = 1'b1;
        apply(t, "perf");
        apply(idle(), "perf");
        apply(t, "perf");
        t = idle(); t.mem_wait = 1'b1;
        repeat (5) apply(t, "perf");
        repeat (2) apply(idle(), "perf");

        for (int i = 0; i < 400; i++) begin
            t = idle();
            t.rst_n    = ($urandom_range(0, 63) != 0);
            t.mem_wait = ($urandom_range(0, 5) == 0);
            t.redirect = ($urandom_range(0, 9) == 0);
            t.mc_start = ($urandom_range(0, 11) == 0);
            t.mc_done  = ($urandom_range(0, 7) == 0);
            t.load     = ($urandom_range(0, 1) == 0);
            t.rd       = 5'($urandom_range(0, 3));
            t.rs1      = 5'($urandom_range(0, 3));
            t.rs2      = 5'($urandom_range(0, 3));
            t.use1     = ($urandom_range(0, 1) == 0);
            t.use2     = ($urandom_range(0, 1) == 0);
            apply(t, "rand");
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_pipe_ctrl.md
Name: ysyx_22041207_pipe_ctrl

Overview:
Central hazard/sequencing controller for the 5-stage pipeline.
- Generates hold (bubble) and clear (flush) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Handles load-use hazards, multi-cycle EX ops and memory wait, plus branch redirects, including redirects that arrive during a stall.
- Sits beside the datapath. Its outputs drive the pipeline registers, which are clocked on negedge clk.

Parameters:
LOAD_LAT, 1, load-use bubbles inserted per hazard (1..7)
CNT_W, 3, width of load-use down-counter

Ports:
clk  in  1  core clock; controller state updates on posedge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  ID-stage source register 1
id_rs2  in  5  ID-stage source register 2
id_use_rs1  in  1  ID inst reads rs1
id_use_rs2  in  1  ID inst reads rs2
ex_rd  in  5  EX-stage destination
ex_is_load  in  1  EX inst is a load
ex_mc_start  in  1  one-cycle pulse: multi-cycle op (mul/div) starts in EX
ex_mc_done  in  1  one-cycle pulse: multi-cycle result ready
ex_redirect  in  1  one-cycle pulse: EX resolved taken branch/jump/mispredict
mem_wait  in  1  level: LSU not ready, memory stage must hold
pc_hold  out  1  PC keeps current value
if_id_bubble  out  1  IF/ID holds
if_id_flush  out  1  IF/ID clears to 0
id_ex_bubble  out  1  ID/EX holds
id_ex_flush  out  1  ID/EX clears (NOP)
ex_mem_bubble  out  1  EX/MEM holds
ex_mem_flush  out  1  EX/MEM clears
mem_wb_flush  out  1  MEM/WB clears
perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature)
perf_flush_cnt  out  32  redirect-flush counter (see Optional Feature)

Behaviour:
- State: RUN, LDU (load-use bubbling), MCW (multi-cycle wait).
- Registered on posedge clk: state, ldu_cnt, redir_pend, mc_done_seen.
- Outputs are combinational from state + inputs and must settle before negedge.
- Reset (rst_n=0, async):
  - state=RUN, ldu_cnt=0, redir_pend=0, mc_done_seen=0, perf counters=0.
  - Outputs forced: if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, mem_wb_flush=1; all hold/bubble outputs 0.
  - Reset mid-stall abandons the stall entirely.
- Hazard definition: hz = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority, highest first: mem_wait > MCW > redirect > load-use.
- mem_wait=1 (any state):
  - Asserted: pc_hold, if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_flush. All other outputs 0.
  - State and ldu_cnt frozen.
  - ex_redirect sets redir_pend; ex_mc_done sets mc_done_seen.
- RUN, mem_wait=0:
  - ex_mc_start: go MCW. Same cycle: pc_hold, if_id_bubble, id_ex_bubble, ex_mem_flush.
  - Else ex_redirect or redir_pend: if_id_flush=1, id_ex_flush=1; clear redir_pend; count one flush. Redirect beats a simultaneous hz (no bubble).
  - Else hz: pc_hold, if_id_bubble, id_ex_flush. If LOAD_LAT>1, go LDU with ldu_cnt=LOAD_LAT-1.
  - Else all outputs 0.
- LDU: same outputs as hz.
  - ldu_cnt decrements each cycle; at ldu_cnt==1, return to RUN next cycle.
  - ex_redirect in LDU: immediate flush outputs instead of bubble; go RUN; ldu_cnt=0.
- MCW:
  - Outputs: pc_hold, if_id_bubble, id_ex_bubble, ex_mem_flush.
  - ex_redirect sets redir_pend.
  - ex_mc_done (or mc_done_seen): go RUN; clear mc_done_seen.
  - Exit cycle still holds. The pending redirect is serviced in the first RUN cycle.
- ex_mc_start and ex_mc_done in the same cycle: treat as done (no wait).
- Simultaneous ex_redirect and ex_mc_start: ex_mc_start wins; redirect is pended.
- flush and bubble for the same register never both 1.

Optional Feature:
Macro: YSYX_22041207_PIPE_PERF_EN.
- Defined:
  - perf_stall_cnt increments every cycle pc_hold=1.
  - perf_flush_cnt increments on each serviced redirect.
  - Both saturate at 0xFFFF_FFFF and clear only on reset.
- Undefined: both ports driven constant 0; no counter flops.

Test Plan:
- Load-use, LOAD_LAT=1: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_hold=if_id_bubble=id_ex_flush=1 for exactly 1 cycle; ex_rd=0 gives no stall.
- LOAD_LAT=3, same hazard -> 3 consecutive bubble cycles; ex_redirect on the 2nd cycle -> flush outputs that cycle, bubble ends.
- ex_mc_start, ex_mc_done 6 cycles later -> pc_hold=1 and ex_mem_flush=1 for 7 cycles, then RUN; ex_redirect on cycle 3 -> if_id_flush=id_ex_flush=1 in the first RUN cycle.
- mem_wait high 4 cycles during MCW with ex_mc_done pulsed inside -> all-hold + mem_wb_flush for 4 cycles, MCW exits on the cycle after mem_wait falls.
- rst_n pulled low mid-LDU -> state RUN immediately, all four flush outputs 1 while low, counters 0.
- With PERF_EN: 2 redirects + 5 stall cycles -> perf_flush_cnt=2, perf_stall_cnt=5; without macro both read 0.
